// File: rtl/memory_access_if.sv
// memory_access_if: execute-to-memory-stage bundle.
//   master (execute side / bench): drives in_*, MEM_READ/MEM_WRITE/REG_WRITE,
//     stall, flush; receives the fwd_* and wb_* results.
//   slave (memory_access): the reverse.
//   fwd_*  : EX/MEM contents for the forwarding unit
//   wb_*   : MEM/WB contents for write-back
interface memory_access_if #(
    parameter int unsigned DATA_W = 32
);
    logic [DATA_W-1:0] in_alu;
    logic [DATA_W-1:0] in_store_data;
    logic [4:0]        in_dest;
    logic              in_valid;
    logic              MEM_READ;
    logic              MEM_WRITE;
    logic              REG_WRITE;
    logic              stall;
    logic              flush;

    logic [DATA_W-1:0] fwd_alu;
    logic [4:0]        fwd_dest;
    logic              fwd_reg_write;
    logic [DATA_W-1:0] wb_data;
    logic [4:0]        wb_dest;
    logic              wb_reg_write;
    logic              wb_misalign;

    modport master (
        output in_alu, in_store_data, in_dest, in_valid,
               MEM_READ, MEM_WRITE, REG_WRITE, stall, flush,
        input  fwd_alu, fwd_dest, fwd_reg_write,
               wb_data, wb_dest, wb_reg_write, wb_misalign
    );

    modport slave (
        input  in_alu, in_store_data, in_dest, in_valid,
               MEM_READ, MEM_WRITE, REG_WRITE, stall, flush,
        output fwd_alu, fwd_dest, fwd_reg_write,
               wb_data, wb_dest, wb_reg_write, wb_misalign
    );
endinterface

// File: rtl/memory_access.sv
// memory_access: memory pipeline stage.
//   EX/MEM register -> word load/store on an internal 2^ADDR_W x 32 data memory
//   -> MEM/WB register.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (pipeline registers only; memory keeps contents)
//   bus   : memory_access_if.slave (execute inputs, stall/flush, fwd_* and wb_* outputs)
module memory_access #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    memory_access_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    // EX/MEM register
    logic              em_valid;
    logic              em_mem_read;
    logic              em_mem_write;
    logic              em_reg_write;
    logic [DATA_W-1:0] em_alu;
    logic [DATA_W-1:0] em_store_data;
    logic [4:0]        em_dest;

    // MEM/WB register
    logic [DATA_W-1:0] wb_data_q;
    logic [4:0]        wb_dest_q;
    logic              wb_reg_write_q;
    logic              wb_misalign_q;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] mem_index;
    logic [DATA_W-1:0] mem_rdata;
    logic              misalign;
    logic              mem_we;

    // Upper address bits are dropped, so addresses wrap modulo memory size.
    assign mem_index = em_alu[ADDR_W+1:2];
    assign misalign  = em_valid & (em_mem_read | em_mem_write) & (em_alu[1:0] != 2'b00);
    // The store sits in EX/MEM for the whole stall and commits only on the
    // releasing edge, giving exactly one write per store.
    assign mem_we    = rst_n & em_valid & em_mem_write & ~misalign & ~bus.stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            em_valid      <= 1'b0;
            em_mem_read   <= 1'b0;
            em_mem_write  <= 1'b0;
            em_reg_write  <= 1'b0;
            em_alu        <= '0;
            em_store_data <= '0;
            em_dest       <= '0;
        end else if (bus.flush) begin
            em_valid      <= 1'b0;
            em_mem_read   <= 1'b0;
            em_mem_write  <= 1'b0;
            em_reg_write  <= 1'b0;
            em_alu        <= '0;
            em_store_data <= '0;
            em_dest       <= '0;
        end else if (!bus.stall) begin
            em_valid      <= bus.in_valid;
            em_mem_read   <= bus.in_valid & bus.MEM_READ;
            em_mem_write  <= bus.in_valid & bus.MEM_WRITE;
            em_reg_write  <= bus.in_valid & bus.REG_WRITE;
            em_alu        <= bus.in_alu;
            em_store_data <= bus.in_store_data;
            em_dest       <= bus.in_dest;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_index] <= em_store_data;
        end
    end

    // Combinational array read captured by the MEM/WB register gives a
    // synchronous read; a store committing on the same edge is not yet visible.
    assign mem_rdata = mem[mem_index];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_data_q      <= '0;
            wb_dest_q      <= '0;
            wb_reg_write_q <= 1'b0;
            wb_misalign_q  <= 1'b0;
        end else if (!bus.stall) begin
            wb_data_q      <= em_mem_read ? (misalign ? '0 : mem_rdata) : em_alu;
            wb_dest_q      <= em_dest;
            wb_reg_write_q <= em_valid & em_reg_write & ~em_mem_write
                              & ~(em_mem_read & misalign);
            wb_misalign_q  <= misalign;
        end
    end

    assign bus.fwd_alu       = em_alu;
    assign bus.fwd_dest      = em_dest;
    assign bus.fwd_reg_write = em_valid & em_reg_write & ~em_mem_read;
    assign bus.wb_data       = wb_data_q;
    assign bus.wb_dest       = wb_dest_q;
    assign bus.wb_reg_write  = wb_reg_write_q;
    assign bus.wb_misalign   = wb_misalign_q;
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: table-driven vectors with a write-back scoreboard queue,
// plus hand-written stall, flush and reset sequences.
module tb_memory_access;
    logic clk;
    logic rst_n;

    memory_access_if #(.DATA_W(32)) bus ();

    memory_access #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        rd;
        logic        wr;
        logic        rw;
        logic [31:0] alu;
        logic [31:0] sdata;
        logic [4:0]  dest;
        logic        f_rw;
        logic [31:0] w_data;
        logic        w_rw;
        logic        w_mis;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  dest;
        logic        rw;
        logic        mis;
    } wb_t;

    vec_t tbl [13];
    wb_t  sb [$];
    wb_t  exp_wb;
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic v, rd, wr, rw,
                                input logic [31:0] alu, sd, input logic [4:0] dest,
                                input logic f_rw, input logic [31:0] w_data,
                                input logic w_rw, w_mis);
        vec_t t;
        t.valid = v; t.rd = rd; t.wr = wr; t.rw = rw;
        t.alu = alu; t.sdata = sd; t.dest = dest;
        t.f_rw = f_rw; t.w_data = w_data; t.w_rw = w_rw; t.w_mis = w_mis;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, rd, wr, rw,
                         input logic [31:0] alu, sd, input logic [4:0] dest);
        bus.in_valid      = v;
        bus.MEM_READ      = rd;
        bus.MEM_WRITE     = wr;
        bus.REG_WRITE     = rw;
        bus.in_alu        = alu;
        bus.in_store_data = sd;
        bus.in_dest       = dest;
    endtask

    task automatic bubble();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wb(input string tag, input logic [31:0] d, input logic [4:0] dest,
                          input logic rw, input logic mis);
        chk({tag, ".wb_data"}, bus.wb_data, d);
        chk({tag, ".wb_dest"}, {27'd0, bus.wb_dest}, {27'd0, dest});
        chk({tag, ".wb_reg_write"}, {31'd0, bus.wb_reg_write}, {31'd0, rw});
        chk({tag, ".wb_misalign"}, {31'd0, bus.wb_misalign}, {31'd0, mis});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //             v  rd wr rw  alu           sdata         dest  f_rw w_data        w_rw w_mis
        tbl[0]  = mk(1, 0, 1, 0, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0,  0, 32'h0000_0010, 0, 0);
        tbl[1]  = mk(1, 1, 0, 1, 32'h0000_0010, 32'h0,         5'd5,  0, 32'hDEAD_BEEF, 1, 0);
        tbl[2]  = mk(1, 0, 0, 1, 32'h0000_1234, 32'h0,         5'd7,  1, 32'h0000_1234, 1, 0);
        tbl[3]  = mk(1, 1, 0, 1, 32'h0000_0013, 32'h0,         5'd3,  0, 32'h0,         0, 1);
        tbl[4]  = mk(1, 0, 1, 0, 32'h0000_0020, 32'h1111_1111, 5'd0,  0, 32'h0000_0020, 0, 0);
        tbl[5]  = mk(1, 0, 1, 0, 32'h0000_0022, 32'h2222_2222, 5'd0,  0, 32'h0000_0022, 0, 1);
        tbl[6]  = mk(1, 1, 0, 1, 32'h0000_0020, 32'h0,         5'd9,  0, 32'h1111_1111, 1, 0);
        tbl[7]  = mk(1, 0, 1, 0, 32'h0000_0400, 32'hCAFE_F00D, 5'd0,  0, 32'h0000_0400, 0, 0);
        tbl[8]  = mk(1, 1, 0, 1, 32'h0000_0000, 32'h0,         5'd1,  0, 32'hCAFE_F00D, 1, 0);
        tbl[9]  = mk(0, 0, 0, 1, 32'h0000_0055, 32'h0,         5'd4,  0, 32'h0000_0055, 0, 0);
        tbl[10] = mk(1, 1, 1, 1, 32'h0000_0010, 32'h3333_3333, 5'd2,  0, 32'hDEAD_BEEF, 0, 0);
        tbl[11] = mk(1, 1, 0, 1, 32'h0000_0010, 32'h0,         5'd6,  0, 32'h3333_3333, 1, 0);
        tbl[12] = mk(1, 0, 0, 1, 32'h0000_ABCD, 32'h0,         5'd0,  1, 32'h0000_ABCD, 1, 0);

        rst_n = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bubble();
        #2;
        rst_n = 1'b0;
        #1;
        chk_wb("reset0", 32'h0, 5'd0, 1'b0, 1'b0);
        chk("reset0.fwd_alu", bus.fwd_alu, 32'h0);
        chk("reset0.fwd_reg_write", {31'd0, bus.fwd_reg_write}, 32'h0);
        #20;
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].valid, tbl[i].rd, tbl[i].wr, tbl[i].rw,
                  tbl[i].alu, tbl[i].sdata, tbl[i].dest);
            exp_wb.data = tbl[i].w_data;
            exp_wb.dest = tbl[i].dest;
            exp_wb.rw   = tbl[i].w_rw;
            exp_wb.mis  = tbl[i].w_mis;
            sb.push_back(exp_wb);
            tick();
            chk($sformatf("vec%0d.fwd_alu", i), bus.fwd_alu, tbl[i].alu);
            chk($sformatf("vec%0d.fwd_dest", i), {27'd0, bus.fwd_dest}, {27'd0, tbl[i].dest});
            chk($sformatf("vec%0d.fwd_reg_write", i), {31'd0, bus.fwd_reg_write},
                {31'd0, tbl[i].f_rw});
            if (sb.size() > 1) begin
                exp_wb = sb.pop_front();
                chk_wb($sformatf("vec%0d", i - 1), exp_wb.data, exp_wb.dest, exp_wb.rw, exp_wb.mis);
            end
        end
        bubble();
        tick();
        exp_wb = sb.pop_front();
        chk_wb("vec12", exp_wb.data, exp_wb.dest, exp_wb.rw, exp_wb.mis);

        // Stall with a store held in EX/MEM
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0077, 32'h0, 5'd8);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'hAAAA_0001, 5'd0);
        tick();
        bus.stall = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'hBBBB_0002, 5'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("stall%0d.fwd_alu", c), bus.fwd_alu, 32'h0000_0040);
            chk_wb($sformatf("stall%0d", c), 32'h0000_0077, 5'd8, 1'b1, 1'b0);
        end
        bus.stall = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 5'd10);
        tick();
        chk_wb("stall_store", 32'h0000_0040, 5'd0, 1'b0, 1'b0);
        bubble();
        tick();
        chk_wb("stall_load", 32'hAAAA_0001, 5'd10, 1'b1, 1'b0);

        // Flush together with stall
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0088, 32'h0, 5'd12);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0099, 32'h0, 5'd11);
        tick();
        chk("preflush.fwd_reg_write", {31'd0, bus.fwd_reg_write}, 32'h1);
        chk("preflush.wb_data", bus.wb_data, 32'h0000_0088);
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        tick();
        chk("flush.fwd_alu", bus.fwd_alu, 32'h0);
        chk("flush.fwd_dest", {27'd0, bus.fwd_dest}, 32'h0);
        chk("flush.fwd_reg_write", {31'd0, bus.fwd_reg_write}, 32'h0);
        chk_wb("flush_hold", 32'h0000_0088, 5'd12, 1'b1, 1'b0);
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bubble();
        tick();
        chk_wb("flush_bubble", 32'h0, 5'd0, 1'b0, 1'b0);

        // Reset with a store in flight
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0050, 32'h1234_5678, 5'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0066, 32'h0, 5'd14);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0050, 32'hFFFF_0000, 5'd0);
        tick();
        chk("prereset.fwd_alu", bus.fwd_alu, 32'h0000_0050);
        chk_wb("prereset", 32'h0000_0066, 5'd14, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset.fwd_alu", bus.fwd_alu, 32'h0);
        chk("reset.fwd_dest", {27'd0, bus.fwd_dest}, 32'h0);
        chk("reset.fwd_reg_write", {31'd0, bus.fwd_reg_write}, 32'h0);
        chk_wb("reset", 32'h0, 5'd0, 1'b0, 1'b0);
        bubble();
        tick();
        #3;
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0050, 32'h0, 5'd13);
        tick();
        bubble();
        tick();
        chk_wb("postreset_load", 32'h1234_5678, 5'd13, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- Stage directly downstream of the execute stage.
- Registers execute results in an EX/MEM pipeline register, performs word loads/stores on an internal synchronous data memory, and presents results through a MEM/WB pipeline register to write-back.
- Also exports EX/MEM contents for the forwarding unit.

Parameters:
ADDR_W, 8, word-address width; data memory holds 2^ADDR_W 32-bit words
DATA_W, 32, datapath width; fixed at 32 for this design

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous reset, active low
in_alu  input  32  ALU result from execute (address for loads/stores, else result)
in_store_data  input  32  register data from execute (store data)
in_dest  input  5  destination register selected in execute
in_valid  input  1  execute slot holds a real instruction
MEM_READ  input  1  instruction is a load
MEM_WRITE  input  1  instruction is a store
REG_WRITE  input  1  instruction writes the register file
stall  input  1  hold both pipeline registers
flush  input  1  replace incoming instruction with a bubble
fwd_alu  output  32  EX/MEM ALU result, for forwarding
fwd_dest  output  5  EX/MEM destination register
fwd_reg_write  output  1  EX/MEM valid & REG_WRITE & ~MEM_READ (forwardable now)
wb_data  output  32  MEM/WB value to write back (load data or ALU result)
wb_dest  output  5  MEM/WB destination register
wb_reg_write  output  1  MEM/WB register-file write enable
wb_misalign  output  1  MEM/WB instruction had a misaligned memory address

Behaviour:
- Reset (rst_n=0, asynchronous): clear all EX/MEM and MEM/WB fields to 0.
  - All outputs read 0.
  - Data memory contents are not reset.
  - Reset mid-operation aborts in-flight instructions; no store completes after reset asserts.
- EX/MEM register on each rising edge:
  - flush=1: load a bubble (valid=0, controls=0, data fields=0), regardless of stall.
  - Else stall=1: hold.
  - Else capture in_* and controls; controls are gated by in_valid.
- Memory access uses EX/MEM contents:
  - Word index = alu[ADDR_W+1:2]; bits above ADDR_W+1 are ignored (address wraps modulo memory size).
  - misalign = valid & (MEM_READ|MEM_WRITE) & (alu[1:0]!=0).
  - Store: memory[index] <= store_data on the edge when valid & MEM_WRITE & ~misalign & ~stall. Exactly one write per store, even under stall.
  - Load: read is synchronous, data registered on the same edge into MEM/WB.
  - A load immediately following a store to the same word returns the new data: the store commits at edge k, the load reads at edge k+1.
  - MEM_READ and MEM_WRITE both set: treat as a store; wb_reg_write forced 0.
- MEM/WB register, on each rising edge when ~stall:
  - wb_data = MEM_READ ? (misalign ? 0 : memory[index]) : alu.
  - wb_dest = dest.
  - wb_reg_write = valid & REG_WRITE & ~MEM_WRITE & ~(MEM_READ & misalign).
  - wb_misalign = misalign.
  - stall=1: hold.
- Latency:
  - Inputs sampled at edge N appear on fwd_* after edge N.
  - The same instruction appears on wb_* after edge N+1.
  - Throughput is one instruction per cycle without stall.
- Forwarding outputs are combinational from the EX/MEM register only. fwd_reg_write is 0 for loads, whose data is not yet available.
- wb_dest=0 is passed through unchanged; write-back ignores register 0.

Test Plan:
- Reset: run traffic, assert rst_n=0 between edges -> all outputs 0 immediately. Store in flight at reset does not modify memory (later load of that word returns its prior value).
- Store/load: store in_alu=0x10, data=0xDEADBEEF, then next cycle load in_alu=0x10, REG_WRITE=1, dest=5 -> two edges after the load is sampled, wb_data=0xDEADBEEF, wb_dest=5, wb_reg_write=1.
- ALU passthrough: in_alu=0x1234, REG_WRITE=1, dest=7, no mem ops -> after edge N, fwd_alu=0x1234, fwd_dest=7, fwd_reg_write=1. After edge N+1, wb_data=0x1234.
- Misaligned: load at 0x13 -> wb_misalign=1, wb_data=0, wb_reg_write=0. Store at 0x22 -> memory at word 8 unchanged.
- Stall/flush: stall 3 cycles with a store in EX/MEM -> single write, outputs frozen. flush=1 together with stall=1 -> EX/MEM becomes bubble, fwd_reg_write=0.
- Wrap: ADDR_W=8, store at 0x400 then load at 0x000 -> load returns the stored value.
